// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-and-add multiplier that computes a 32x32 unsigned
// product modulo 2^32, with an exact overflow flag. It does the arithmetic by
// steering an external combinational 32-bit ALU, one ALU pass per ADD, SHL or
// SRL step.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start, op_a, op_b     request and operands; sampled only while idle
//   busy, done            busy from the cycle after accept through DONE; done pulses in DONE
//   product, ovf          low 32 bits of op_a*op_b and the overflow flag; held until the next DONE
//   alu_*  (outputs)      ALU operand and control lines; neutral add setting while idle
//   alu_out, alu_c_out,   ALU result, adder carry and zero flag, returned in the same cycle
//   alu_zero
module alu_mul_seq #(
  parameter logic [1:0] SLL_CODE = 2'b00,
  parameter logic [1:0] SRL_CODE = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        ovf,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_addr_src_b_sel,
  output logic [1:0]  alu_primary_out_sel,
  output logic [1:0]  alu_shifter_input_sel,
  output logic [1:0]  alu_shift_type,
  output logic [4:0]  alu_shift_amnt,
  output logic        alu_shifter_enbl,
  input  logic [31:0] alu_out,
  input  logic        alu_c_out,
  input  logic        alu_zero
);

  localparam int unsigned DW = 32;
  localparam int unsigned SAW = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SRL,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   mcand_q, mcand_d;
  logic [DW-1:0]   mplr_q, mplr_d;
  logic            ovf_acc_q, ovf_acc_d;
  logic [DW-1:0]   product_q, product_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [1:0]      shift_type_q, shift_type_d;
  logic [SAW-1:0]  shift_amnt_q, shift_amnt_d;
  logic            shifter_enbl_q, shifter_enbl_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      mcand_q        <= '0;
      mplr_q         <= '0;
      ovf_acc_q      <= 1'b0;
      product_q      <= '0;
      ovf_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      shift_type_q   <= SLL_CODE;
      shift_amnt_q   <= '0;
      shifter_enbl_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      mcand_q        <= mcand_d;
      mplr_q         <= mplr_d;
      ovf_acc_q      <= ovf_acc_d;
      product_q      <= product_d;
      ovf_q          <= ovf_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      shift_type_q   <= shift_type_d;
      shift_amnt_q   <= shift_amnt_d;
      shifter_enbl_q <= shifter_enbl_d;
    end
  end

  // Next state, datapath updates, and registered outputs derived from the next state
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    mcand_d        = mcand_q;
    mplr_d         = mplr_q;
    ovf_acc_d      = ovf_acc_q;
    product_d      = product_q;
    ovf_d          = ovf_q;
    alu_a_d        = '0;
    alu_b_d        = '0;
    shift_type_d   = SLL_CODE;
    shift_amnt_d   = '0;
    shifter_enbl_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d   = op_a;
          mplr_d    = op_b;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          if (op_b == '0)   state_d = S_DONE;
          else if (op_b[0]) state_d = S_ADD;
          else              state_d = S_SHL;
        end
      end
      S_ADD: begin
        acc_d     = alu_out;
        ovf_acc_d = ovf_acc_q | alu_c_out;
        state_d   = S_SHL;
      end
      S_SHL: begin
        mcand_d = alu_out;
        // A set bit leaves the multiplicand while higher multiplier bits still
        // need it, so the true product is at least 2^32.
        if (mcand_q[DW-1] && (mplr_q[DW-1:1] != '0)) ovf_acc_d = 1'b1;
        state_d = S_SRL;
      end
      S_SRL: begin
        mplr_d = alu_out;
        if (alu_zero)        state_d = S_DONE;
        else if (alu_out[0]) state_d = S_ADD;
        else                 state_d = S_SHL;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    // Result lands on the same edge that raises done
    if (state_d == S_DONE) begin
      product_d = acc_d;
      ovf_d     = ovf_acc_d;
    end

    // ALU lines are presented for the state being entered so the combinational
    // result is ready within that state's cycle.
    unique case (state_d)
      S_ADD: begin
        alu_a_d = acc_d;
        alu_b_d = mcand_d;
      end
      S_SHL: begin
        alu_a_d        = mcand_d;
        shifter_enbl_d = 1'b1;
        shift_type_d   = SLL_CODE;
        shift_amnt_d   = SAW'(1);
      end
      S_SRL: begin
        alu_a_d        = mplr_d;
        shifter_enbl_d = 1'b1;
        shift_type_d   = SRL_CODE;
        shift_amnt_d   = SAW'(1);
      end
      default: begin
        alu_a_d = '0;
      end
    endcase
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign product               = product_q;
  assign ovf                   = ovf_q;
  assign alu_a                 = alu_a_q;
  assign alu_b                 = alu_b_q;
  assign alu_shift_type        = shift_type_q;
  assign alu_shift_amnt        = shift_amnt_q;
  assign alu_shifter_enbl      = shifter_enbl_q;
  assign alu_addr_src_b_sel    = 1'b0;
  assign alu_primary_out_sel   = 2'b01;
  assign alu_shifter_input_sel = 2'b00;

endmodule
